sonar_ping_sequencer: RTL and testbench

- Downstream consumer of the 20.48 MHz PLL output; the whole block runs in that clock domain.
- Divides the clock to the 40 kHz transducer carrier (20.48 MHz / 512).
- Sequences one sonar ping: drive burst, ring-down blanking, echo listen window with a 40 kHz sample strobe, then a done pulse.
- Feeds the transducer H-bridge pins and the echo ADC capture logic.

---
 rtl/sonar_pkg.sv | 31 +++
 rtl/sonar_carrier_div.sv | 39 +++
 rtl/sonar_ping_sequencer.sv | 120 ++++++++++++
 tb/tb_sonar_ping_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar ping sequencer.
package sonar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        BLANK  = 2'd2,
        LISTEN = 2'd3
    } state_t;

    localparam int CLK_HZ     = 20480000;
    localparam int CARRIER_HZ = 40000;

    // 20.48 MHz / 40 kHz = 512 cycles per carrier period
    localparam int DEF_HALF_PERIOD    = CLK_HZ / (2 * CARRIER_HZ);
    localparam int DEF_BURST_PERIODS  = 8;
    localparam int DEF_BLANK_PERIODS  = 40;
    localparam int DEF_LISTEN_PERIODS = 1200;

    // Counter width for values 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sonar_carrier_div.sv
// Carrier prescaler + phase flop. period_end flags the last cycle of a full
// carrier period; phase_nxt lets the parent register outputs that line up
// with the phase of the following cycle.
module sonar_carrier_div
    import sonar_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic phase_nxt,
    output logic period_end
);

    localparam int PW = cnt_w(HALF_PERIOD);
    localparam logic [PW-1:0] PRESC_LAST = PW'(HALF_PERIOD - 1);

    logic [PW-1:0] presc;
    logic          phase;
    logic          half_end;

    assign half_end   = (presc == PRESC_LAST);
    assign period_end = half_end && phase;
    assign phase_nxt  = clear ? 1'b0 : (half_end ? ~phase : phase);

    // Prescaler wraps every half period; clear restarts on a period boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            phase <= 1'b0;
        end else begin
            phase <= phase_nxt;
            if (clear || half_end) presc <= '0;
            else                   presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/sonar_ping_sequencer.sv
// One-shot sonar ping: drive burst, ring-down blanking, listen window with a
// carrier-rate sample strobe, then a done pulse. All outputs are registered
// from next-state values so they line up with the state they describe.
module sonar_ping_sequencer
    import sonar_pkg::*;
#(
    parameter int HALF_PERIOD    = DEF_HALF_PERIOD,
    parameter int BURST_PERIODS  = DEF_BURST_PERIODS,
    parameter int BLANK_PERIODS  = DEF_BLANK_PERIODS,
    parameter int LISTEN_PERIODS = DEF_LISTEN_PERIODS,
    localparam int IDX_W = (LISTEN_PERIODS > 1) ? $clog2(LISTEN_PERIODS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             tx_p,
    output logic             tx_n,
    output logic             busy,
    output logic             listen,
    output logic             sample_tick,
    output logic [IDX_W-1:0] sample_idx,
    output logic             done
);

    localparam int CNT_W = cnt_w(max3(BURST_PERIODS, BLANK_PERIODS, LISTEN_PERIODS));
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_PERIODS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_PERIODS - 1);
    localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_PERIODS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] per_cnt, per_cnt_n;
    logic             clear;
    logic             phase_nxt;
    logic             period_end;
    logic             done_n;
    logic             tick_n;

    sonar_carrier_div #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .phase_nxt (phase_nxt),
        .period_end(period_end)
    );

    // Next state; abort wins over a coincident period-end transition
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = BURST;
            end
            BURST: begin
                if (abort)                                  state_n = IDLE;
                else if (period_end && per_cnt == BURST_LAST) state_n = BLANK;
            end
            BLANK: begin
                if (abort)                                  state_n = IDLE;
                else if (period_end && per_cnt == BLANK_LAST) state_n = LISTEN;
            end
            LISTEN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (period_end && per_cnt == LISTEN_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Counters restart on every state entry and stay parked while idle
    always_comb begin
        clear     = (state_n != state) || (state_n == IDLE);
        per_cnt_n = per_cnt;
        if (clear)           per_cnt_n = '0;
        else if (period_end) per_cnt_n = per_cnt + CNT_W'(1);
        // strobe on listen entry and on the first cycle of each later period
        tick_n = (state_n == LISTEN) && ((state != LISTEN) || period_end);
    end

    // State and period counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            per_cnt <= '0;
        end else begin
            state   <= state_n;
            per_cnt <= per_cnt_n;
        end
    end

    // Registered outputs derived from the upcoming state and phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_p        <= 1'b0;
            tx_n        <= 1'b0;
            busy        <= 1'b0;
            listen      <= 1'b0;
            sample_tick <= 1'b0;
            sample_idx  <= '0;
            done        <= 1'b0;
        end else begin
            tx_p        <= (state_n == BURST) && !phase_nxt;
            tx_n        <= (state_n == BURST) &&  phase_nxt;
            busy        <= (state_n != IDLE);
            listen      <= (state_n == LISTEN);
            sample_tick <= tick_n;
            done        <= done_n;
            if (tick_n)                 sample_idx <= IDX_W'(per_cnt_n);
            else if (state_n != LISTEN) sample_idx <= '0;
        end
    end

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Bench: small-parameter instance checked cycle by cycle against a ping
// timeline model; a second instance at the real carrier rate checks timing.
module tb_sonar_ping_sequencer;

    localparam int H = 4, BU = 2, BL = 1, LI = 3;
    localparam int DH = 256, DBU = 8, DBL = 2, DLI = 24;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       tx_p, tx_n, busy, listen, sample_tick, done;
    logic [1:0] sample_idx;

    logic       d_start, d_abort;
    logic       d_tx_p, d_tx_n, d_busy, d_listen, d_tick, d_done;
    logic [4:0] d_idx;

    int checks = 0, failures = 0;
    int cyc = 0;

    // model: is a ping active, offset into it, done expected this cycle
    bit m_act = 0, m_done = 0;
    int m_off = 0;
    int last_done = -1, first_tx = -1, done_cnt = 0;

    always #5 clk = ~clk;

    sonar_ping_sequencer #(
        .HALF_PERIOD(H), .BURST_PERIODS(BU), .BLANK_PERIODS(BL), .LISTEN_PERIODS(LI)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tx_p(tx_p), .tx_n(tx_n), .busy(busy), .listen(listen),
        .sample_tick(sample_tick), .sample_idx(sample_idx), .done(done)
    );

    sonar_ping_sequencer #(
        .HALF_PERIOD(DH), .BURST_PERIODS(DBU), .BLANK_PERIODS(DBL), .LISTEN_PERIODS(DLI)
    ) dut_d (
        .clk(clk), .rst(rst), .start(d_start), .abort(d_abort),
        .tx_p(d_tx_p), .tx_n(d_tx_n), .busy(d_busy), .listen(d_listen),
        .sample_tick(d_tick), .sample_idx(d_idx), .done(d_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs at a given offset into a ping, from the timeline alone
    function automatic void expect_out(input bit act, input int off, input int h,
                                       input int bu, input int bl, input int li,
                                       output bit e_txp, output bit e_txn, output bit e_busy,
                                       output bit e_lis, output bit e_tick, output int e_idx);
        int b, ls;
        b      = bu * 2 * h;
        ls     = b + bl * 2 * h;
        e_busy = act;
        e_txp  = act && off < b && ((off / h) % 2 == 0);
        e_txn  = act && off < b && ((off / h) % 2 == 1);
        e_lis  = act && off >= ls && off < ls + li * 2 * h;
        e_tick = e_lis && ((off - ls) % (2 * h) == 0);
        e_idx  = e_lis ? (off - ls) / (2 * h) : 0;
    endfunction

    task automatic check_main();
        bit p, n, b, l, t;
        int idx;
        expect_out(m_act, m_off, H, BU, BL, LI, p, n, b, l, t, idx);
        chk("tx_p", tx_p, p);
        chk("tx_n", tx_n, n);
        chk("busy", busy, b);
        chk("listen", listen, l);
        chk("sample_tick", sample_tick, t);
        chk("done", done, m_done);
        if (t) chk("sample_idx", sample_idx, idx);
        if (done === 1'b1) begin last_done = cyc; done_cnt++; end
        if (tx_p === 1'b1 && first_tx < 0) first_tx = cyc;
    endtask

    task automatic model_step();
        int last;
        last = (BU + BL + LI) * 2 * H - 1;
        if (m_act) begin
            if (abort)              begin m_act = 0; m_done = 0; end
            else if (m_off == last) begin m_act = 0; m_done = 1; end
            else                    begin m_off++;   m_done = 0; end
        end else begin
            m_done = 0;
            if (start) begin m_act = 1; m_off = 0; end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_main();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) run_cycle();
    endtask

    initial begin
        int s, dc, d_off, total, last_rise, ticks, last_idx, last_tick, burst_cyc;
        bit p, n, b, l, t;
        int idx;

        rst = 1'b1; start = 1'b0; abort = 1'b0; d_start = 1'b0; d_abort = 1'b0;
        #12;
        chk("rst_tx_p", tx_p, 0);   chk("rst_tx_n", tx_n, 0);
        chk("rst_busy", busy, 0);   chk("rst_listen", listen, 0);
        chk("rst_tick", sample_tick, 0); chk("rst_idx", sample_idx, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1; rst = 1'b0; cyc = 0;

        // 1: single start at cycle 10
        run_until(10);
        start = 1'b1; run_cycle(); start = 1'b0;
        run_until(70);
        chk("t1_first_tx", first_tx, 11);
        chk("t1_done_cycle", last_done, 59);
        chk("t1_done_count", done_cnt, 1);

        // 2: start held high -> back-to-back pings
        start = 1'b1;
        run_until(190);
        start = 1'b0;
        run_until(260);
        chk("t2_done_count", done_cnt, 4);

        // 3: abort mid-burst, then fresh start
        s = cyc;
        start = 1'b1; run_cycle(); start = 1'b0;
        run_until(s + 10);
        abort = 1'b1; run_cycle(); abort = 1'b0;
        run_until(s + 15);
        dc = done_cnt;
        start = 1'b1; run_cycle(); start = 1'b0;
        run_cycle();
        run_until(s + 80);
        chk("t3_done_count", done_cnt - dc, 1);

        // 4: abort coincident with the final listen period end
        s = cyc; dc = done_cnt;
        start = 1'b1; run_cycle(); start = 1'b0;
        run_until(s + 1 + (BU + BL + LI) * 2 * H - 1);
        abort = 1'b1; run_cycle(); abort = 1'b0;
        run_until(s + 70);
        chk("t4_no_done", done_cnt - dc, 0);

        // 5: asynchronous reset mid-listen, then a full ping
        s = cyc;
        start = 1'b1; run_cycle(); start = 1'b0;
        run_until(s + 1 + 35);
        #2; rst = 1'b1; #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_listen", listen, 0);
        chk("t5_async_tx", {tx_p, tx_n}, 0);
        m_act = 0; m_done = 0;
        run_cycle(); run_cycle();
        rst = 1'b0;
        s = cyc; dc = done_cnt;
        start = 1'b1; run_cycle(); start = 1'b0;
        run_until(s + 60);
        chk("t5_full_ping_done", last_done, s + 1 + (BU + BL + LI) * 2 * H);

        // random start/abort traffic
        repeat (600) begin
            start = ($urandom_range(7) == 0);
            abort = ($urandom_range(29) == 0);
            run_cycle();
        end
        start = 1'b0; abort = 1'b0;
        run_until(cyc + 60);

        // 6: real carrier rate instance
        d_start = 1'b1; @(posedge clk); #1; d_start = 1'b0;
        total = (DBU + DBL + DLI) * 2 * DH;
        last_rise = -1; ticks = 0; last_idx = -1; last_tick = -1; burst_cyc = 0;
        for (d_off = 0; d_off < total; d_off++) begin
            @(negedge clk);
            expect_out(1'b1, d_off, DH, DBU, DBL, DLI, p, n, b, l, t, idx);
            chk("d_tx_p", d_tx_p, p);
            chk("d_tx_n", d_tx_n, n);
            chk("d_busy", d_busy, 1);
            chk("d_listen", d_listen, l);
            chk("d_tick", d_tick, t);
            if (t) chk("d_idx", d_idx, idx);
            if (d_tx_p === 1'b1 || d_tx_n === 1'b1) burst_cyc++;
            if (d_tx_p === 1'b1 && (d_off == 0 || (d_off % DH) == 0) && (d_off / DH) % 2 == 0) begin
                if (last_rise >= 0) chk("d_carrier_period", d_off - last_rise, 512);
                last_rise = d_off;
            end
            if (d_tick === 1'b1) begin
                if (last_tick >= 0) chk("d_tick_spacing", d_off - last_tick, 512);
                last_tick = d_off; ticks++; last_idx = int'(d_idx);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("d_done", d_done, 1);
        chk("d_busy_end", d_busy, 0);
        chk("d_burst_cycles", burst_cyc, 4096);
        chk("d_tick_count", ticks, DLI);
        chk("d_last_idx", last_idx, DLI - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
